// File: rtl/aes_shiftmix_col_if.sv
// Valid/ready bus between SubBytes, the ShiftRows/MixColumns stage and AddRoundKey.
// slave is the stage's view; master is the view of whatever drives and consumes it.
interface aes_shiftmix_col_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        in_last_rnd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [1:0]  out_col;
    logic        out_last;

    modport slave (
        input  in_valid, in_word, in_last_rnd, out_ready,
        output in_ready, out_valid, out_word, out_col, out_last
    );

    modport master (
        output in_valid, in_word, in_last_rnd, out_ready,
        input  in_ready, out_valid, out_word, out_col, out_last
    );
endinterface

// File: rtl/aes_shiftmix_col.sv
// AES round stage: buffers four SubBytes columns, then emits ShiftRows (+ MixColumns
// unless final round) one column per handshake.
module aes_shiftmix_col #(
    parameter bit MIX_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    aes_shiftmix_col_if.slave   bus
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned COL_W  = 2;
    localparam int unsigned NCOL   = 4;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [COL_W-1:0]    r_col;
    logic [WORD_W-1:0]   r_buf [NCOL];
    logic                r_last;

    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_in_fire;
    logic                w_out_fire;

    logic [COL_W-1:0]    w_c1;
    logic [COL_W-1:0]    w_c2;
    logic [COL_W-1:0]    w_c3;
    logic [7:0]          w_t0;
    logic [7:0]          w_t1;
    logic [7:0]          w_t2;
    logic [7:0]          w_t3;
    logic [WORD_W-1:0]   w_shift;
    logic [WORD_W-1:0]   w_out_word;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and handshake outputs; the column counter decides when a state is complete
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_in_fire    = 1'b0;
        w_out_fire   = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_in_fire = 1'b1;
                    if (r_col == COL_W'(NCOL - 1)) begin
                        w_next_state = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_out_fire = 1'b1;
                    if (r_col == COL_W'(NCOL - 1)) begin
                        w_next_state = ST_LOAD;
                    end
                end
            end
            default: begin
                w_next_state = ST_LOAD;
            end
        endcase
    end

    // Buffer, column counter and final-round flag; counter wraps 3->0 exactly on FSM transitions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col  <= '0;
            r_last <= 1'b0;
            for (int i = 0; i < int'(NCOL); i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_in_fire) begin
            r_buf[r_col] <= bus.in_word;
            if (r_col == '0) begin
                r_last <= bus.in_last_rnd;
            end
            r_col <= r_col + COL_W'(1);
        end else if (w_out_fire) begin
            r_col <= r_col + COL_W'(1);
        end
    end

    // ShiftRows: row r of the output column comes from buffer column (col + r) mod 4
    assign w_c1    = r_col + COL_W'(1);
    assign w_c2    = r_col + COL_W'(2);
    assign w_c3    = r_col + COL_W'(3);
    assign w_t0    = r_buf[r_col][31:24];
    assign w_t1    = r_buf[w_c1][23:16];
    assign w_t2    = r_buf[w_c2][15:8];
    assign w_t3    = r_buf[w_c3][7:0];
    assign w_shift = {w_t0, w_t1, w_t2, w_t3};

    generate
        if (MIX_EN) begin : g_mix
            logic [7:0]        w_x0;
            logic [7:0]        w_x1;
            logic [7:0]        w_x2;
            logic [7:0]        w_x3;
            logic [WORD_W-1:0] w_mix;

            assign w_x0  = xtime(w_t0);
            assign w_x1  = xtime(w_t1);
            assign w_x2  = xtime(w_t2);
            assign w_x3  = xtime(w_t3);
            // 3a = xtime(a) ^ a
            assign w_mix = {w_x0 ^ w_x1 ^ w_t1 ^ w_t2 ^ w_t3,
                            w_t0 ^ w_x1 ^ w_x2 ^ w_t2 ^ w_t3,
                            w_t0 ^ w_t1 ^ w_x2 ^ w_x3 ^ w_t3,
                            w_x0 ^ w_t0 ^ w_t1 ^ w_t2 ^ w_x3};
            assign w_out_word = r_last ? w_shift : w_mix;
        end else begin : g_nomix
            assign w_out_word = w_shift;
        end
    endgenerate

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_word  = w_out_word;
    assign bus.out_col   = r_col;
    assign bus.out_last  = (r_col == COL_W'(NCOL - 1));

endmodule

// File: tb/tb_aes_shiftmix_col.sv
// Directed bench for aes_shiftmix_col: FIPS-197 vectors, backpressure, reset and a GF(2^8) reference model.
module tb_aes_shiftmix_col;

    typedef logic [31:0] words_t [4];

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    aes_shiftmix_col_if bus ();

    aes_shiftmix_col #(.MIX_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Whole-state reference: ShiftRows on the 4x4 matrix, then matrix product for MixColumns
    task automatic model(input words_t w, input bit last, output words_t o);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] base [4];
        logic [7:0] acc;
        base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = w[c][31-8*r -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r][c] = s[r][(c+r)%4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (last) begin
                    acc = t[r][c];
                end else begin
                    acc = 8'h00;
                    for (int k = 0; k < 4; k++)
                        acc = acc ^ gmul(base[(k-r+4)%4], t[k][c]);
                end
                o[c][31-8*r -: 8] = acc;
            end
        end
    endtask

    task automatic load_words(input words_t w, input int n, input bit lr0, input bit lr_rest, input bit rnd);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            @(negedge clk);
            if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.in_valid    = 1'b1;
            bus.in_word     = w[i];
            bus.in_last_rnd = (i == 0) ? lr0 : lr_rest;
            while (!bus.in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 20) check($sformatf("load_timeout_w%0d", i), 32'(bus.in_ready), 32'd1);
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
        end
    endtask

    task automatic recv_cols(input words_t exp, input int first, input int lastc, input string tag, input bit rnd);
        for (int i = first; i <= lastc; i++) begin
            int guard;
            guard = 0;
            @(negedge clk);
            if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.out_ready = 1'b1;
            while (!bus.out_valid && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check($sformatf("%s_valid%0d", tag, i), 32'(bus.out_valid), 32'd1);
            check($sformatf("%s_word%0d", tag, i), bus.out_word, exp[i]);
            check($sformatf("%s_col%0d", tag, i), 32'(bus.out_col), 32'(i));
            check($sformatf("%s_last%0d", tag, i), 32'(bus.out_last), 32'(i == 3));
            check($sformatf("%s_inrdy%0d", tag, i), 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1 bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        words_t v1, e1, e2, vdb, edb, vr, er;
        checks = 0;
        errors = 0;
        v1  = '{32'hd42711ae, 32'he0bf98f1, 32'hb8b45de5, 32'h1e415230};
        e1  = '{32'h046681e5, 32'he0cb199a, 32'h48f8d37a, 32'h2806264c};
        e2  = '{32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5};
        vdb = '{32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345};
        edb = '{32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc};

        bus.in_valid    = 1'b0;
        bus.in_word     = 32'h0;
        bus.in_last_rnd = 1'b0;
        bus.out_ready   = 1'b0;
        rst             = 1'b1;

        // Values held during reset
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_word", bus.out_word, 32'h0);
        check("rst_out_col", 32'(bus.out_col), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);

        // FIPS-197 round 1 with MixColumns, including one-cycle latency
        load_words(v1, 4, 1'b0, 1'b0, 1'b0);
        check("t1_latency", 32'(bus.out_valid), 32'd1);
        recv_cols(e1, 0, 3, "t1", 1'b0);
        check("t1_back_to_load", 32'(bus.in_ready), 32'd1);

        // Final round: ShiftRows only
        load_words(v1, 4, 1'b1, 1'b0, 1'b0);
        recv_cols(e2, 0, 3, "t2", 1'b0);

        // MixColumns known column
        load_words(vdb, 4, 1'b0, 1'b0, 1'b0);
        recv_cols(edb, 0, 3, "t3", 1'b0);

        // Backpressure on column 2, with an upstream word offered during EMIT
        load_words(v1, 4, 1'b0, 1'b0, 1'b0);
        recv_cols(e1, 0, 1, "t4a", 1'b0);
        @(negedge clk);
        bus.out_ready   = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_word     = 32'hdeadbeef;
        bus.in_last_rnd = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t4_hold_word%0d", k), bus.out_word, 32'h48f8d37a);
            check($sformatf("t4_hold_col%0d", k), 32'(bus.out_col), 32'd2);
            check($sformatf("t4_hold_inrdy%0d", k), 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.in_valid    = 1'b0;
        bus.in_last_rnd = 1'b0;
        recv_cols(e1, 2, 3, "t4b", 1'b0);

        // Random states with random gaps against the reference model
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) vr[c] = $urandom;
            model(vr, (s == 2), er);
            load_words(vr, 4, (s == 2), (s != 2), 1'b1);
            recv_cols(er, 0, 3, $sformatf("t4r%0d", s), 1'b1);
        end

        // Reset after two words loaded
        load_words(vdb, 2, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5a_in_ready", 32'(bus.in_ready), 32'd1);
        check("t5a_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        load_words(v1, 4, 1'b0, 1'b0, 1'b0);
        recv_cols(e1, 0, 3, "t5a", 1'b0);

        // Reset after two words emitted
        load_words(v1, 4, 1'b1, 1'b0, 1'b0);
        recv_cols(e2, 0, 1, "t5b_pre", 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5b_in_ready", 32'(bus.in_ready), 32'd1);
        check("t5b_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5b_out_word", bus.out_word, 32'h0);
        check("t5b_out_col", 32'(bus.out_col), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5b_no_valid", 32'(bus.out_valid), 32'd0);
        load_words(vdb, 4, 1'b0, 1'b0, 1'b0);
        recv_cols(edb, 0, 3, "t5b", 1'b0);

        // in_last_rnd only honoured on column 0
        load_words(v1, 4, 1'b0, 1'b1, 1'b0);
        recv_cols(e1, 0, 3, "t6", 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
